// File: rtl/prog_loader_pkg.sv
// Shared constants for the boot loader and core controller.
//   core_mode_t    : core controller modes (LOAD until the loader reports done, then EXEC)
//   loader_state_t : prog_loader FSM states
//   SYNC_BYTE_DEF  : default handshake byte, both received and echoed
package prog_loader_pkg;

  typedef enum logic [1:0] {
    MODE_LOAD,
    MODE_EXEC
  } core_mode_t;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    ACK,
    DONE
  } loader_state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hAA;

endpackage

// File: rtl/prog_loader_packer.sv
// byte_packer: 4-byte big-endian assembler with a 2-bit byte counter.
//   clk, rstn  : clock, async active-low reset
//   clr        : synchronous counter/shift-register clear
//   byte_vld   : byte_in is consumed this cycle
//   byte_in    : incoming byte, first byte of a group lands in word[31:24]
//   word_valid : combinational, high in the cycle the 4th byte is consumed
//   word       : assembled word, valid with word_valid
module byte_packer (
  input  logic        clk,
  input  logic        rstn,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt;
  logic [23:0] sr;

  // The 4th byte is taken straight from the input so the word is ready in
  // the same cycle; only the first three bytes need storage.
  assign word_valid = byte_vld && (cnt == 2'd3);
  assign word       = {sr, byte_in};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= 2'd0;
      sr  <= 24'd0;
    end else if (clr) begin
      cnt <= 2'd0;
      sr  <= 24'd0;
    end else if (byte_vld) begin
      cnt <= cnt + 2'd1;  // wraps 3 -> 0 on each completed word
      sr  <= {sr[15:0], byte_in};
    end
  end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: boot-time loader feeding instruction memory from the UART.
// Waits for the sync byte, reads a big-endian 32-bit word count, writes that
// many big-endian words to consecutive imem addresses, echoes the sync byte
// and raises done.
//   clk, rstn          : clock, async active-low reset
//   rx_data/rx_ready   : byte strobe from uart_rx
//   ferr               : framing error, qualified by rx_ready
//   tx_data/tx_start   : ack byte request to uart_tx
//   tx_busy            : uart_tx busy
//   imem_we/addr/wdata : instruction memory write port
//   aa_received        : pulse when the sync byte is accepted
//   aa_sent, done      : levels, set once the ack is handed off
//   err                : sticky framing-error flag
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int          ADDR_W    = 15,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  input  logic              ferr,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              aa_received,
  output logic              aa_sent,
  output logic              done,
  output logic              err
);

  loader_state_t state, state_nx;

  logic        acc;
  logic        sync_hit;
  logic        pk_vld;
  logic        word_valid;
  logic [31:0] word;
  logic [31:0] len_q;
  logic [31:0] widx;
  logic [31:0] widx_inc;
  logic        in_range;
  logic        wr_fire;
  logic        len_load;
  logic        tx_fire;

  assign acc      = rx_ready && !ferr;
  assign sync_hit = (state == IDLE) && acc && (rx_data == SYNC_BYTE);
  assign pk_vld   = acc && ((state == LEN) || (state == DATA));
  assign widx_inc = widx + 32'd1;
  // Words past the end of memory are counted but never written (no wrap).
  assign in_range = (widx >> ADDR_W) == 32'd0;
  assign tx_data  = SYNC_BYTE;

  byte_packer u_packer (
    .clk        (clk),
    .rstn       (rstn),
    .clr        (state == IDLE),
    .byte_vld   (pk_vld),
    .byte_in    (rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_nx = state;
    wr_fire  = 1'b0;
    len_load = 1'b0;
    tx_fire  = 1'b0;
    case (state)
      IDLE: if (sync_hit) state_nx = LEN;
      LEN: if (word_valid) begin
        len_load = 1'b1;
        state_nx = (word == 32'd0) ? ACK : DATA;
      end
      DATA: if (word_valid) begin
        wr_fire = 1'b1;
        if (widx_inc == len_q) state_nx = ACK;
      end
      ACK: if (!tx_busy) begin
        tx_fire  = 1'b1;
        state_nx = DONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      len_q       <= 32'd0;
      widx        <= 32'd0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= 32'd0;
      tx_start    <= 1'b0;
      aa_received <= 1'b0;
      aa_sent     <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_nx;
      aa_received <= sync_hit;
      imem_we     <= wr_fire && in_range;
      tx_start    <= tx_fire;
      if (len_load) len_q <= word;
      if (wr_fire) begin
        imem_addr  <= widx[ADDR_W-1:0];
        imem_wdata <= word;
        widx       <= widx_inc;
      end
      if (rx_ready && ferr) err <= 1'b1;
      // tx_start went out on the cycle DONE was entered; flags follow a cycle later.
      if (state == DONE) begin
        done    <= 1'b1;
        aa_sent <= 1'b1;
      end
    end
  end

endmodule
